// File: rtl/piece_motion_ctrl.sv
// ---------------------------------------------------------------------------
// piece_motion_ctrl
//   Falling-tetromino controller. Owns the active piece's shape code,
//   rotation and top-left pixel position. It applies keyboard moves,
//   rotation with wall-kick, and gravity, and keeps the piece inside the
//   playfield. The shape-size lookup sits downstream and answers
//   combinationally in the same cycle.
//
//   Optional feature: define HARD_DROP_EN to enable the space-bar hard drop
//   (DROP state). Without it, 0x2C is just an unmapped key.
//
// Ports
//   Clk           in   1   system clock
//   Reset         in   1   synchronous, active-high reset
//   frame_tick    in   1   one-Clk pulse per video frame
//   keycode       in   8   current USB HID keycode, 0 = none
//   spawn         in   1   request a new piece (honoured in IDLE only)
//   spawn_shape   in   3   shape code 1..7, 0 = invalid
//   shape_size_x  in   10  lookup width (pixels) for shape_num/rotation
//   shape_size_y  in   10  lookup height (pixels) for shape_num/rotation
//   shape_num     out  3   active shape code to the lookup
//   rotation      out  2   active rotation 0..3 to the lookup
//   piece_x       out  10  top-left x of the piece bounding box
//   piece_y       out  10  top-left y of the piece bounding box
//   active        out  1   piece in play (FALL / ROT_CHK / DROP)
//   landed        out  1   one-Clk pulse when the piece locks
// ---------------------------------------------------------------------------
module piece_motion_ctrl #(
  parameter int FIELD_X_MIN = 240,
  parameter int FIELD_X_MAX = 399,
  parameter int FIELD_Y_MAX = 479,
  parameter int CELL        = 16,
  parameter int GRAV_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       spawn,
  input  logic [2:0] spawn_shape,
  input  logic [9:0] shape_size_x,
  input  logic [9:0] shape_size_y,
  output logic [2:0] shape_num,
  output logic [1:0] rotation,
  output logic [9:0] piece_x,
  output logic [9:0] piece_y,
  output logic       active,
  output logic       landed
);

  localparam int GW = (GRAV_FRAMES > 1) ? $clog2(GRAV_FRAMES) : 1;
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_FRAMES - 1);

  localparam logic [9:0]  CELL10   = 10'(CELL);
  localparam logic [9:0]  XMIN10   = 10'(FIELD_X_MIN);
  localparam logic [9:0]  SPAWN_X  = 10'(FIELD_X_MIN + 4 * CELL);
  localparam logic [9:0]  XEND10   = 10'(FIELD_X_MAX + 1);
  localparam logic [10:0] CELL11   = 11'(CELL);
  localparam logic [10:0] XMIN11   = 11'(FIELD_X_MIN);
  localparam logic [10:0] XMAX11   = 11'(FIELD_X_MAX);
  localparam logic [10:0] YMAX11   = 11'(FIELD_Y_MAX);

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
`ifdef HARD_DROP_EN
  localparam logic [7:0] KEY_SPACE = 8'h2C;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FALL,
    ROT_CHK,
`ifdef HARD_DROP_EN
    DROP,
`endif
    LANDED
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      shape_q, shape_d;
  logic [1:0]      rot_q, rot_d;
  logic [1:0]      oldRot_q, oldRot_d;
  logic [9:0]      pieceX_q, pieceX_d;
  logic [9:0]      pieceY_q, pieceY_d;
  logic [GW-1:0]   gravCnt_q, gravCnt_d;
  logic [7:0]      prevKey_q, prevKey_d;

  logic            newKey;
  logic            dropReq;
  logic            gravStep;
  logic            canLeft, canRight, canDown;
  logic [10:0]     x11, y11, sx11, sy11;

  // A key acts only on the first frame it is seen; releasing it re-arms it.
  assign newKey = (keycode != prevKey_q) && (keycode != 8'h00);

`ifdef HARD_DROP_EN
  assign dropReq = newKey && (keycode == KEY_SPACE);
`else
  assign dropReq = 1'b0;
`endif

  // All boundary sums are formed in 11 bits so they cannot wrap.
  assign x11  = {1'b0, pieceX_q};
  assign y11  = {1'b0, pieceY_q};
  assign sx11 = {1'b0, shape_size_x};
  assign sy11 = {1'b0, shape_size_y};

  assign canLeft  = x11 >= (XMIN11 + CELL11);
  assign canRight = (x11 + sx11 + CELL11 - 11'd1) <= XMAX11;
  assign canDown  = (y11 + sy11 + CELL11 - 11'd1) <= YMAX11;
  assign gravStep = (gravCnt_q == GRAV_LAST) || (keycode == KEY_S);

  // State and datapath registers, all cleared by the synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      shape_q   <= 3'd0;
      rot_q     <= 2'd0;
      oldRot_q  <= 2'd0;
      pieceX_q  <= XMIN10;
      pieceY_q  <= 10'd0;
      gravCnt_q <= '0;
      prevKey_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shape_q   <= shape_d;
      rot_q     <= rot_d;
      oldRot_q  <= oldRot_d;
      pieceX_q  <= pieceX_d;
      pieceY_q  <= pieceY_d;
      gravCnt_q <= gravCnt_d;
      prevKey_q <= prevKey_d;
    end
  end

  // Next-state and datapath update. In FALL the rotation is applied
  // optimistically and validated one cycle later in ROT_CHK, once the
  // lookup reports the size for the new orientation. If gravity locks the
  // piece on the same tick as a rotate, the lock wins and rotation holds.
  always_comb begin
    state_d   = state_q;
    shape_d   = shape_q;
    rot_d     = rot_q;
    oldRot_d  = oldRot_q;
    pieceX_d  = pieceX_q;
    pieceY_d  = pieceY_q;
    gravCnt_d = gravCnt_q;
    prevKey_d = frame_tick ? keycode : prevKey_q;

    case (state_q)
      IDLE: begin
        if (spawn && (spawn_shape != 3'd0)) begin
          shape_d   = spawn_shape;
          rot_d     = 2'd0;
          pieceX_d  = SPAWN_X;
          pieceY_d  = 10'd0;
          gravCnt_d = '0;
          state_d   = FALL;
        end
      end

      FALL: begin
        if (frame_tick) begin
          if (dropReq) begin
`ifdef HARD_DROP_EN
            state_d = DROP;
`endif
          end else begin
            if (newKey && (keycode == KEY_W)) begin
              oldRot_d = rot_q;
              rot_d    = rot_q + 2'd1;
              state_d  = ROT_CHK;
            end else if (newKey && (keycode == KEY_A) && canLeft) begin
              pieceX_d = pieceX_q - CELL10;
            end else if (newKey && (keycode == KEY_D) && canRight) begin
              pieceX_d = pieceX_q + CELL10;
            end

            if (gravStep) begin
              gravCnt_d = '0;
              if (canDown) begin
                pieceY_d = pieceY_q + CELL10;
              end else begin
                rot_d   = rot_q;
                state_d = LANDED;
              end
            end else begin
              gravCnt_d = gravCnt_q + GW'(1);
            end
          end
        end
      end

      ROT_CHK: begin
        // Sizes now describe the new rotation: undo if it pokes through
        // the floor, otherwise kick it back inside the right wall.
        if ((y11 + sy11) > (YMAX11 + 11'd1)) begin
          rot_d = oldRot_q;
        end else if ((x11 + sx11) > (XMAX11 + 11'd1)) begin
          pieceX_d = XEND10 - shape_size_x;
        end
        state_d = FALL;
      end

`ifdef HARD_DROP_EN
      DROP: begin
        if (canDown) begin
          pieceY_d = pieceY_q + CELL10;
        end else begin
          state_d = LANDED;
        end
      end
`endif

      LANDED: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the current state.
  always_comb begin
    active = 1'b0;
    landed = 1'b0;
    case (state_q)
      FALL:    active = 1'b1;
      ROT_CHK: active = 1'b1;
`ifdef HARD_DROP_EN
      DROP:    active = 1'b1;
`endif
      LANDED:  landed = 1'b1;
      default: begin
        active = 1'b0;
        landed = 1'b0;
      end
    endcase
  end

  assign shape_num = shape_q;
  assign rotation  = rot_q;
  assign piece_x   = pieceX_q;
  assign piece_y   = pieceY_q;

endmodule
